route_allocator: RTL and testbench
==================================

# route_allocator

Switch allocator for the 4-port mesh router. It accepts per-input route requests, each naming a desired output direction, and arbitrates contending inputs round-robin per output. It holds each output reserved for the granted input until that input signals packet end. Its registered per-output select drives the crossbar data steering, and its per-input grant/route signals go back to the input buffers.

## Interface
Parameters:
- N, 4, number of router ports (inputs = outputs); SEL_W = $clog2(N)
- TIMEOUT, 256, watchdog limit in cycles (used only with ROUTE_TIMEOUT_EN)

Ports:
- clk  input  1  single clock for the whole block
- rst  input  1  reset, asynchronous, active-low
- req_valid  input  N  input i requests an output; held high until granted
- req_dest  input  N*SEL_W  field i = requested output for input i
- release  input  N  1-cycle pulse: input i has sent its tail flit
- grant  output  N  1-cycle pulse: input i's request won
- in_route  output  N*SEL_W  field i = output reserved by input i (valid while in_busy[i])
- in_busy  output  N  input i holds a reservation
- out_sel  output  N*SEL_W  field o = input driving output o
- out_busy  output  N  output o is reserved
- timeout_err  output  N  1-cycle pulse: output o was force-released (ROUTE_TIMEOUT_EN only; otherwise tied 0)

## Operation
- Direction encoding: 0 North, 1 South, 2 West, 3 East.
- Each output has a 2-state FSM:
  - FREE -> BUSY when at least one eligible input requests it. Eligible means req_valid[i] & ~in_busy[i] & req_dest[i]==o.
  - BUSY -> FREE on release[i] from the owning input.
- Arbitration for each FREE output is round-robin. The pointer starts at 0; after a grant to input w, the pointer moves to (w+1) mod N. Pointers of outputs with no grant are unchanged.
- One input requests one output at a time, so several outputs can grant in the same cycle without conflict.
- On grant:
  - the owning input is latched into out_sel[o];
  - in_route[i] is set to o, and in_busy[i] and out_busy[o] are set;
  - grant[i] pulses.
- req_valid from an input that already holds a reservation is ignored.
- release from an input with no reservation is ignored.
- The requester must hold req_dest stable while req_valid is high. The block does not check this.

## Timing
- Reset value of all outputs is 0, and all pointers are 0.
- Reset is asserted asynchronously, and all state clears immediately, including mid-packet.
- Grant latency: a request present at edge k produces grant, out_sel and busy flags valid after edge k. These are all registered outputs.
- grant[i] is high for exactly one cycle. The requester drops req_valid on the cycle after it sees grant.
- On release at edge k:
  - out_busy[o] and in_busy[i] clear after edge k;
  - out_sel[o] holds its last value while free.
- The earliest re-grant of a released output is at edge k+1. Arbitration at edge k sees the output as busy.
- Release and a new request from the same input in the same cycle: the release is applied, and the request is evaluated the following cycle.

## Configuration
- ROUTE_TIMEOUT_EN defined:
  - each output has a counter of width $clog2(TIMEOUT+1). It clears on grant and counts each BUSY cycle.
  - when the count reaches TIMEOUT, the output is force-released exactly like a release pulse, and timeout_err[o] pulses for 1 cycle.
  - a release and the timeout in the same cycle count as a normal release, with no error.
- Not defined: there is no counter, and timeout_err is constant 0.

## Structure
- Shared package noc_pkg holds:
  - the direction constants DIR_NORTH/SOUTH/WEST/EAST;
  - the localparam for SEL_W.
- Sub-module rr_arbiter: an N-way round-robin arbiter with a request vector, an enable, a one-hot grant and a registered pointer. It is instantiated once per output.

## Test plan
- Reset, then input 0 requests output 3 (East): grant[0] pulses one cycle later, out_sel[3]=0, in_route[0]=3, out_busy=4'b1000.
- Inputs 1 and 2 both request output 0 with pointer=0: input 1 is granted. After input 1 releases, input 2 is granted at edge k+1, and the pointer moves to 3.
- All four inputs request distinct outputs (0->1, 1->0, 2->3, 3->2) in the same cycle: all four grant in the same cycle, and out_sel = {2,3,0,1} for outputs 3..0.
- Spurious release[2] while input 2 is idle, plus req_valid from a busy input: no state change and no grant.
- rst asserted while outputs 1 and 3 are busy: everything reads 0 immediately. After rst deasserts, the first request is granted normally.
- ROUTE_TIMEOUT_EN with TIMEOUT=8: after a grant and no release, out_busy clears after 8 busy cycles and timeout_err pulses. A release on cycle 8 produces no error.

Source files
------------

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared mesh-router constants and types
package noc_pkg;

    localparam int N_PORTS = 4;
    localparam int SEL_W   = $clog2(N_PORTS);

    localparam logic [SEL_W-1:0] DIR_NORTH = SEL_W'(0);
    localparam logic [SEL_W-1:0] DIR_SOUTH = SEL_W'(1);
    localparam logic [SEL_W-1:0] DIR_WEST  = SEL_W'(2);
    localparam logic [SEL_W-1:0] DIR_EAST  = SEL_W'(3);

    typedef enum logic {
        OUT_FREE = 1'b0,
        OUT_BUSY = 1'b1
    } out_state_e;

endpackage

// File: rtl/route_allocator_if.sv
// rtl/route_allocator_if.sv - input-buffer <-> switch-allocator handshake bundle
interface route_allocator_if #(
    parameter int N = noc_pkg::N_PORTS
) ();
    localparam int SW = $clog2(N);

    logic [N-1:0]    req_valid;
    logic [N*SW-1:0] req_dest;
    // named pkt_release because release is a reserved word
    logic [N-1:0]    pkt_release;
    logic [N-1:0]    grant;
    logic [N*SW-1:0] in_route;
    logic [N-1:0]    in_busy;
    logic [N*SW-1:0] out_sel;
    logic [N-1:0]    out_busy;
    logic [N-1:0]    timeout_err;

    modport master (
        output req_valid, req_dest, pkt_release,
        input  grant, in_route, in_busy, out_sel, out_busy, timeout_err
    );

    modport slave (
        input  req_valid, req_dest, pkt_release,
        output grant, in_route, in_busy, out_sel, out_busy, timeout_err
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-way round-robin arbiter with registered priority pointer
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    output logic [N-1:0] gnt_o
);
    localparam int SW = $clog2(N);

    logic [SW-1:0] ptr_q, ptr_d;
    int            idx;

    // scan from the pointer upward; the first requester found wins
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        idx   = 0;
        if (en_i) begin
            for (int k = 0; k < N; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= N) idx = idx - N;
                if (req_i[idx] && (gnt_o == '0)) begin
                    gnt_o[idx] = 1'b1;
                    ptr_d      = (idx == N - 1) ? '0 : SW'(idx + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/route_allocator.sv
// rtl/route_allocator.sv - switch allocator, per-output reservation; ROUTE_TIMEOUT_EN adds a watchdog
module route_allocator
    import noc_pkg::*;
#(
    parameter int N       = N_PORTS,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    route_allocator_if.slave  bus
);
    localparam int SW = $clog2(N);

    logic [N-1:0]  elig    [N];
    logic [N-1:0]  arb_gnt [N];
    out_state_e    state_q [N], state_d [N];
    logic [SW-1:0] out_sel_q  [N], out_sel_d  [N];
    logic [SW-1:0] in_route_q [N], in_route_d [N];
    logic [N-1:0]  in_busy_q, in_busy_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [N-1:0]  terr_q, terr_d;
    logic [N-1:0]  rel_out, to_fire;

    // elig[o][i]: input i is idle, requesting, and pointing at output o
    always_comb begin
        for (int o = 0; o < N; o++) begin
            for (int i = 0; i < N; i++) begin
                elig[o][i] = bus.req_valid[i] & ~in_busy_q[i]
                           & (bus.req_dest[i*SW +: SW] == SW'(o));
            end
        end
    end

    for (genvar o = 0; o < N; o++) begin : g_arb
        rr_arbiter #(.N(N)) u_arb (
            .clk   (clk),
            .rst_n (rst),
            .req_i (elig[o]),
            .en_i  (state_q[o] == OUT_FREE),
            .gnt_o (arb_gnt[o])
        );
    end

    always_comb begin
        for (int o = 0; o < N; o++) begin
            rel_out[o] = (state_q[o] == OUT_BUSY) & bus.pkt_release[out_sel_q[o]];
        end
    end

`ifdef ROUTE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q [N], cnt_d [N];

    always_comb begin
        for (int o = 0; o < N; o++) begin
            cnt_d[o]   = '0;
            to_fire[o] = 1'b0;
            if (state_q[o] == OUT_BUSY) begin
                cnt_d[o]   = cnt_q[o] + 1'b1;
                to_fire[o] = (cnt_d[o] == CW'(TIMEOUT));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < N; o++) cnt_q[o] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // a real release in the same cycle wins, so no error is flagged
    assign terr_d = to_fire & ~rel_out;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign to_fire        = '0;
    assign terr_d         = '0;
`endif

    always_comb begin
        state_d    = state_q;
        out_sel_d  = out_sel_q;
        in_route_d = in_route_q;
        in_busy_d  = in_busy_q;
        grant_d    = '0;
        for (int o = 0; o < N; o++) begin
            if (state_q[o] == OUT_BUSY) begin
                if (rel_out[o] || to_fire[o]) begin
                    state_d[o]                = OUT_FREE;
                    in_busy_d[out_sel_q[o]]   = 1'b0;
                end
            end else if (arb_gnt[o] != '0) begin
                state_d[o] = OUT_BUSY;
                for (int i = 0; i < N; i++) begin
                    if (arb_gnt[o][i]) begin
                        out_sel_d[o]  = SW'(i);
                        in_route_d[i] = SW'(o);
                        in_busy_d[i]  = 1'b1;
                        grant_d[i]    = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                state_q[k]    <= OUT_FREE;
                out_sel_q[k]  <= '0;
                in_route_q[k] <= '0;
            end
            in_busy_q <= '0;
            grant_q   <= '0;
            terr_q    <= '0;
        end else begin
            state_q    <= state_d;
            out_sel_q  <= out_sel_d;
            in_route_q <= in_route_d;
            in_busy_q  <= in_busy_d;
            grant_q    <= grant_d;
            terr_q     <= terr_d;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_out
        assign bus.in_route[k*SW +: SW] = in_route_q[k];
        assign bus.out_sel[k*SW +: SW]  = out_sel_q[k];
        assign bus.out_busy[k]          = (state_q[k] == OUT_BUSY);
    end

    assign bus.grant       = grant_q;
    assign bus.in_busy     = in_busy_q;
    assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_route_allocator.sv
// tb/tb_route_allocator.sv - randomized bench against a reservation-table model of route_allocator
module tb_route_allocator;
    import noc_pkg::*;

    localparam int N   = 4;
    localparam int SW  = 2;
    localparam int TMO = 8;
`ifdef ROUTE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    route_allocator_if #(.N(N)) bus ();

    route_allocator #(.N(N), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reservation table model
    int owner [N];
    int sel   [N];
    int ptr   [N];
    int age   [N];
    int route [N];
    bit ibusy [N];
    bit exp_grant [N];
    bit exp_terr  [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            owner[k] = -1; sel[k] = 0; ptr[k] = 0; age[k] = 0; route[k] = 0;
            ibusy[k] = 1'b0; exp_grant[k] = 1'b0; exp_terr[k] = 1'b0;
        end
    endtask

    task automatic model_step(input logic [N-1:0] rv, input logic [N*SW-1:0] dp, input logic [N-1:0] rel);
        int was_owner [N];
        bit was_busy  [N];
        int w;
        int i;
        bit r;
        bit t;
        for (int k = 0; k < N; k++) begin
            was_owner[k] = owner[k];
            was_busy[k]  = ibusy[k];
            exp_grant[k] = 1'b0;
            exp_terr[k]  = 1'b0;
        end
        for (int o = 0; o < N; o++) begin
            if (was_owner[o] >= 0) begin
                w = was_owner[o];
                r = rel[w];
                age[o] = age[o] + 1;
                t = TO_EN && (age[o] == TMO);
                if (r || t) begin
                    owner[o] = -1;
                    ibusy[w] = 1'b0;
                    if (!r) exp_terr[o] = 1'b1;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    i = (ptr[o] + k) % N;
                    if (rv[i] && !was_busy[i] && (int'(dp[i*SW +: SW]) == o)) begin
                        owner[o] = i; sel[o] = i; route[i] = o; ibusy[i] = 1'b1;
                        exp_grant[i] = 1'b1; age[o] = 0; ptr[o] = (i + 1) % N;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0]    eg, eib, eob, et;
        logic [N*SW-1:0] esel, eroute, groute;
        for (int k = 0; k < N; k++) begin
            eg[k]  = exp_grant[k];
            eib[k] = ibusy[k];
            eob[k] = (owner[k] >= 0);
            et[k]  = exp_terr[k];
            esel[k*SW +: SW]   = SW'(sel[k]);
            eroute[k*SW +: SW] = ibusy[k] ? SW'(route[k]) : '0;
            groute[k*SW +: SW] = ibusy[k] ? bus.in_route[k*SW +: SW] : '0;
        end
        check({tag, ".grant"},    32'(bus.grant),       32'(eg));
        check({tag, ".in_busy"},  32'(bus.in_busy),     32'(eib));
        check({tag, ".out_busy"}, 32'(bus.out_busy),    32'(eob));
        check({tag, ".out_sel"},  32'(bus.out_sel),     32'(esel));
        check({tag, ".in_route"}, 32'(groute),          32'(eroute));
        check({tag, ".terr"},     32'(bus.timeout_err), 32'(et));
    endtask

    task automatic do_cycle(input string tag, input logic [N-1:0] rv, input logic [N*SW-1:0] dp,
                            input logic [N-1:0] rel);
        bus.req_valid   = rv;
        bus.req_dest    = dp;
        bus.pkt_release = rel;
        model_step(rv, dp, rel);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    function automatic logic [N*SW-1:0] dests(input int d3, input int d2, input int d1, input int d0);
        return {SW'(d3), SW'(d2), SW'(d1), SW'(d0)};
    endfunction

    task automatic check_zero(input string tag);
        check({tag, ".grant"},    32'(bus.grant),       32'h0);
        check({tag, ".in_busy"},  32'(bus.in_busy),     32'h0);
        check({tag, ".out_busy"}, 32'(bus.out_busy),    32'h0);
        check({tag, ".out_sel"},  32'(bus.out_sel),     32'h0);
        check({tag, ".in_route"}, 32'(bus.in_route),    32'h0);
        check({tag, ".terr"},     32'(bus.timeout_err), 32'h0);
    endtask

    bit              pend  [N];
    logic [SW-1:0]   pdest [N];
    logic [N-1:0]    rv_r, rel_r;
    logic [N*SW-1:0] dp_r;
    int              busy_cnt, terr_cnt;

    initial begin
        bus.req_valid   = '0;
        bus.req_dest    = '0;
        bus.pkt_release = '0;
        model_reset();
        #12;
        check_zero("reset");
        #10 rst = 1'b1;

        // single request to East
        do_cycle("t1a", 4'b0001, dests(0, 0, 0, int'(DIR_EAST)), 4'b0000);
        check("t1.grant",    32'(bus.grant),              32'h1);
        check("t1.out_sel3", 32'(bus.out_sel[3*SW +: SW]), 32'h0);
        check("t1.in_route0",32'(bus.in_route[1:0]),      32'h3);
        check("t1.out_busy", 32'(bus.out_busy),           32'h8);
        do_cycle("t1b", 4'b0000, '0, 4'b0000);
        check("t1.grant_pulse", 32'(bus.grant), 32'h0);
        do_cycle("t1c", 4'b0000, '0, 4'b0001);

        // contention on North, round-robin then pointer at 3
        do_cycle("t2a", 4'b0110, dests(0, 0, 0, 0), 4'b0000);
        check("t2.first", 32'(bus.grant), 32'h2);
        do_cycle("t2b", 4'b0100, dests(0, 0, 0, 0), 4'b0000);
        do_cycle("t2c", 4'b0100, dests(0, 0, 0, 0), 4'b0010);
        check("t2.no_same_edge", 32'(bus.grant), 32'h0);
        do_cycle("t2d", 4'b0100, dests(0, 0, 0, 0), 4'b0000);
        check("t2.second", 32'(bus.grant), 32'h4);
        do_cycle("t2e", 4'b1001, dests(0, 0, 0, 0), 4'b0100);
        do_cycle("t2f", 4'b1001, dests(0, 0, 0, 0), 4'b0000);
        check("t2.ptr3", 32'(bus.grant), 32'h8);
        do_cycle("t2g", 4'b0001, dests(0, 0, 0, 0), 4'b1000);
        do_cycle("t2h", 4'b0001, dests(0, 0, 0, 0), 4'b0000);
        do_cycle("t2i", 4'b0000, '0, 4'b0001);

        // four disjoint routes in one cycle
        do_cycle("t3", 4'b1111, dests(int'(DIR_WEST), int'(DIR_EAST), int'(DIR_NORTH), int'(DIR_SOUTH)), 4'b0000);
        check("t3.grant",   32'(bus.grant),   32'hF);
        check("t3.out_sel", 32'(bus.out_sel), 32'b10_11_00_01);

        // spurious release and request from busy inputs
        do_cycle("t4a", 4'b0000, '0, 4'b0100);
        do_cycle("t4b", 4'b0011, dests(0, 0, 3, 3), 4'b0100);
        check("t4.grant",    32'(bus.grant),    32'h0);
        check("t4.out_busy", 32'(bus.out_busy), 32'h7);

        // asynchronous reset mid-packet
        do_cycle("t5a", 4'b0000, '0, 4'b1111);
        do_cycle("t5b", 4'b0101, dests(0, 3, 0, 1), 4'b0000);
        check("t5.out_busy", 32'(bus.out_busy), 32'hA);
        bus.req_valid = '0; bus.pkt_release = '0;
        #3 rst = 1'b0;
        #1 check_zero("t5.rst");
        model_reset();
        #2 rst = 1'b1;
        do_cycle("t5c", 4'b0010, dests(0, 0, 2, 0), 4'b0000);
        check("t5.regrant", 32'(bus.grant), 32'h2);
        check("t5.sel2",    32'(bus.out_sel[2*SW +: SW]), 32'h1);
        do_cycle("t5d", 4'b0000, '0, 4'b0010);

        if (TO_EN) begin
            do_cycle("t6a", 4'b0001, dests(0, 0, 0, 2), 4'b0000);
            busy_cnt = 1; terr_cnt = 0;
            for (int k = 0; k < 12; k++) begin
                do_cycle("t6b", 4'b0000, '0, 4'b0000);
                if (bus.out_busy[2]) busy_cnt++;
                if (bus.timeout_err[2]) terr_cnt++;
            end
            check("t6.busy_cycles", 32'(busy_cnt), 32'(TMO));
            check("t6.terr_pulses", 32'(terr_cnt), 32'h1);
            do_cycle("t6c", 4'b0001, dests(0, 0, 0, 2), 4'b0000);
            for (int k = 0; k < TMO - 1; k++) do_cycle("t6d", 4'b0000, '0, 4'b0000);
            do_cycle("t6e", 4'b0000, '0, 4'b0001);
            check("t6.rel_no_err", 32'(bus.timeout_err), 32'h0);
            check("t6.rel_free",   32'(bus.out_busy),    32'h0);
        end

        // randomized traffic
        for (int k = 0; k < N; k++) begin pend[k] = 1'b0; pdest[k] = '0; end
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                if (pend[k] && exp_grant[k]) pend[k] = 1'b0;
                if (!pend[k] && !ibusy[k] && ($urandom % 3 == 0)) begin
                    pend[k]  = 1'b1;
                    pdest[k] = SW'($urandom % N);
                end
                rv_r[k] = pend[k] | (ibusy[k] & ($urandom % 8 == 0));
                dp_r[k*SW +: SW] = pend[k] ? pdest[k] : SW'($urandom % N);
                rel_r[k] = ibusy[k] ? ($urandom % 4 == 0) : ($urandom % 10 == 0);
            end
            do_cycle("rand", rv_r, dp_r, rel_r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
